jt89_decim: RTL and testbench

JT89_DECIM -- requirements
Module: jt89_decim

---
 rtl/jt89_decim.sv | 150 +++++++++++++++
 tb/tb_jt89_decim.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/jt89_decim.sv
// Decimating output stage for the jt89 PSG mix: block-averages 2^DECIM_W samples,
// then applies a left-shift gain with saturation. Optional DC blocker via JT89_DC_REMOVE_EN.
module jt89_decim #(
  parameter int DECIM_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  input  logic signed [11:0] din,
  input  logic        [2:0]  gain,
  input  logic               clip_clr,
  output logic signed [15:0] sample,
  output logic               sample_valid,
  output logic               clip
);

  localparam int AW = 12 + DECIM_W;

  logic signed [AW-1:0] acc_reg;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] sum_shr;
  logic                 last;
  logic signed [11:0]   avg_reg;
  logic                 avg_valid_reg;

  assign sum     = acc_reg + AW'(din);
  assign sum_shr = sum >>> DECIM_W;

  generate
    if (DECIM_W > 0) begin : g_cnt
      logic [DECIM_W-1:0] cnt_reg;
      assign last = &cnt_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (cen) begin
          cnt_reg <= last ? '0 : cnt_reg + 1'b1;
        end
      end
    end else begin : g_nocnt
      assign last = 1'b1;
    end
  endgenerate

  // Stage 1: accumulate; the block average leaves on the final sample of each block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg       <= '0;
      avg_reg       <= '0;
      avg_valid_reg <= 1'b0;
    end else begin
      avg_valid_reg <= 1'b0;
      if (cen) begin
        if (last) begin
          acc_reg       <= '0;
          avg_reg       <= sum_shr[11:0];
          avg_valid_reg <= 1'b1;
        end else begin
          acc_reg <= sum;
        end
      end
    end
  end

  logic signed [11:0] x_val;
  logic               x_valid;

`ifdef JT89_DC_REMOVE_EN
  // dc_reg carries the DC estimate with 6 fractional bits; one-pole tracker, alpha = 1/64.
  logic signed [17:0] dc_reg;
  logic signed [18:0] dc_diff;
  logic signed [12:0] x_full;
  logic signed [17:0] dc_int;
  logic signed [11:0] x_reg;
  logic               x_valid_reg;

  assign dc_diff = (19'(avg_reg) <<< 6) - 19'(dc_reg);
  assign dc_int  = dc_reg >>> 6;
  assign x_full  = 13'(avg_reg) - 13'(dc_int);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dc_reg      <= '0;
      x_reg       <= '0;
      x_valid_reg <= 1'b0;
    end else begin
      x_valid_reg <= avg_valid_reg;
      if (avg_valid_reg) begin
        dc_reg <= dc_reg + 18'(dc_diff >>> 6);
        if (x_full > 13'sd2047)
          x_reg <= 12'sd2047;
        else if (x_full < -13'sd2048)
          x_reg <= -12'sd2048;
        else
          x_reg <= x_full[11:0];
      end
    end
  end

  assign x_val   = x_reg;
  assign x_valid = x_valid_reg;
`else
  assign x_val   = avg_reg;
  assign x_valid = avg_valid_reg;
`endif

  // Gain stage: 2047 << 7 still fits in 20 signed bits, so the shift itself never wraps.
  logic signed [19:0] shifted_reg;
  logic               shifted_valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shifted_reg       <= '0;
      shifted_valid_reg <= 1'b0;
    end else begin
      shifted_valid_reg <= x_valid;
      if (x_valid)
        shifted_reg <= 20'(x_val) <<< gain;
    end
  end

  logic ovf_hi;
  logic ovf_lo;
  assign ovf_hi = shifted_reg > 20'sd32767;
  assign ovf_lo = shifted_reg < -20'sd32768;

  // Saturation stage; a clip event wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      clip         <= 1'b0;
    end else begin
      sample_valid <= shifted_valid_reg;
      if (shifted_valid_reg) begin
        if (ovf_hi)
          sample <= 16'sh7fff;
        else if (ovf_lo)
          sample <= -16'sh8000;
        else
          sample <= shifted_reg[15:0];
      end
      if (shifted_valid_reg && (ovf_hi || ovf_lo))
        clip <= 1'b1;
      else if (clip_clr)
        clip <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jt89_decim.sv
// Directed bench for jt89_decim (DECIM_W=2): block averaging, gain, saturation,
// clip flag, reset abort and full-rate input; DC-blocker build runs a decay test.
module tb_jt89_decim;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cen = 1'b0;
  logic signed [11:0] din = '0;
  logic        [2:0]  gain = '0;
  logic               clip_clr = 1'b0;
  logic signed [15:0] sample;
  logic               sample_valid;
  logic               clip;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef JT89_DC_REMOVE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  jt89_decim #(.DECIM_W(2)) dut (
    .clk(clk), .rst(rst), .cen(cen), .din(din), .gain(gain),
    .clip_clr(clip_clr), .sample(sample), .sample_valid(sample_valid), .clip(clip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Feeds one 4-sample block on consecutive clocks and checks the output pulse timing.
  // g_late >= 0 changes gain after the last cen; clr asserts clip_clr on the saturating edge.
  task automatic run_block(input int d0, input int d1, input int d2, input int d3,
                           input int g_late, input int exp_s, input int exp_clip,
                           input bit clr, input string tag);
    int d[4];
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cen = 1'b1;
      din = 12'(d[i]);
    end
    @(negedge clk);
    cen = 1'b0;
    if (g_late >= 0) gain = 3'(g_late);
    chk({tag, "_early0"}, int'(sample_valid), 0);
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk);
      chk({tag, "_early"}, int'(sample_valid), 0);
      if (k == LAT - 1 && clr) clip_clr = 1'b1;
    end
    @(negedge clk);
    clip_clr = 1'b0;
    chk({tag, "_valid"}, int'(sample_valid), 1);
    chk({tag, "_sample"}, int'(sample), exp_s);
    chk({tag, "_clip"}, int'(clip), exp_clip);
    @(negedge clk);
    chk({tag, "_pulse"}, int'(sample_valid), 0);
  endtask

  initial begin
    int pulses;
    int exp_v;
    int prev_abs;
    int cur_abs;
    int wait_cnt;

    // cen during reset must be ignored
    cen = 1'b1;
    din = 12'sd500;
    repeat (3) @(negedge clk);
    chk("rst_sample", int'(sample), 0);
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_clip", int'(clip), 0);
    cen = 1'b0;
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      pulses += int'(sample_valid);
    end
    chk("rst_cen_ignored", pulses, 0);

`ifdef JT89_DC_REMOVE_EN
    gain = 3'd0;
    run_block(1000, 1000, 1000, 1000, -1, 1000, 0, 1'b0, "dc_first");
    prev_abs = 1000;
    for (int b = 1; b < 400; b++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        cen = 1'b1;
        din = 12'sd1000;
      end
      @(negedge clk);
      cen = 1'b0;
      wait_cnt = 0;
      while (!sample_valid && wait_cnt < 10) begin
        @(negedge clk);
        wait_cnt++;
      end
      if (wait_cnt >= 10) begin
        chk("dc_timeout", 0, 1);
        break;
      end
      cur_abs = (sample < 0) ? -int'(sample) : int'(sample);
      chk("dc_monotonic", int'(cur_abs <= prev_abs), 1);
      prev_abs = cur_abs;
    end
    chk("dc_final_small", int'(prev_abs < 16), 1);
`else
    gain = 3'd0;
    run_block(100, 100, 100, 100, -1, 100, 0, 1'b0, "avg100");
    repeat (3) @(negedge clk);
    chk("hold_sample", int'(sample), 100);
    run_block(-5, -6, -5, -6, -1, -6, 0, 1'b0, "floor_neg");
    run_block(7, 8, 9, 10, -1, 8, 0, 1'b0, "floor_pos");
    run_block(100, 100, 100, 100, 3, 800, 0, 1'b0, "gain_late");
    gain = 3'd4;
    run_block(2047, 2047, 2047, 2047, -1, 32752, 0, 1'b0, "edge_hi");
    run_block(-2048, -2048, -2048, -2048, -1, -32768, 0, 1'b0, "edge_lo");
    gain = 3'd7;
    run_block(2047, 2047, 2047, 2047, -1, 32767, 1, 1'b0, "sat_hi");
    run_block(-2048, -2048, -2048, -2048, -1, -32768, 1, 1'b0, "sat_lo");
    @(negedge clk);
    clip_clr = 1'b1;
    @(negedge clk);
    clip_clr = 1'b0;
    chk("clip_cleared", int'(clip), 0);
    run_block(2047, 2047, 2047, 2047, -1, 32767, 1, 1'b1, "clr_vs_set");

    // reset mid-block discards the partial accumulation
    gain = 3'd0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cen = 1'b1;
      din = 12'sd500;
    end
    @(negedge clk);
    cen = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_clip", int'(clip), 0);
    rst = 1'b0;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      pulses += int'(sample_valid);
    end
    chk("midrst_no_output", pulses, 0);
    run_block(8, 8, 8, 8, -1, 8, 0, 1'b0, "after_rst");

    // full-rate ramp 0..31: a pulse every 4th clock, values 1,5,...,29
    pulses = 0;
    for (int j = 0; j < 38; j++) begin
      @(negedge clk);
      exp_v = int'(j >= 6 && j <= 34 && (j % 4) == 2);
      chk("ramp_valid", int'(sample_valid), exp_v);
      if (exp_v == 1) begin
        chk("ramp_sample", int'(sample), 4 * ((j - 6) / 4) + 1);
      end
      pulses += int'(sample_valid);
      cen = (j < 32);
      din = 12'(j);
    end
    chk("ramp_count", pulses, 8);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
